// File: rtl/phase_sequencer.sv
// Purpose: instruction-cycle sequencer (FETCH/DECODE/EXEC/WB) with fetch handshake, retire counter and timeout flag.
// Latency: mem_req rises one cycle after run is sampled; 4 cycles per instruction with immediate ack and no stall.
// Backpressure: stall holds DECODE/EXEC/WB in place; FETCH waits on mem_ack up to TIMEOUT cycles, then aborts.
module phase_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             stall,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             ph_fetch,
  output logic             ph_decode,
  output logic             ph_exec,
  output logic             ph_wb,
  output logic [1:0]       phase,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             timeout_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Last wait-count value before the fetch is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;

  // State register plus the registered status outputs, all cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic: phase stepping, fetch wait counting, retire bookkeeping.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (run && !terr_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        // stall has no effect here; only the memory handshake matters.
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (!stall) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!stall) state_d = S_WB;
      end
      S_WB: begin
        if (!stall) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (run && !terr_q) ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: strobes and phase index come from the state register only.
  always_comb begin
    ph_fetch  = 1'b0;
    ph_decode = 1'b0;
    ph_exec   = 1'b0;
    ph_wb     = 1'b0;
    phase     = 2'd0;
    case (state_q)
      S_FETCH:  ph_fetch = 1'b1;
      S_DECODE: begin ph_decode = 1'b1; phase = 2'd1; end
      S_EXEC:   begin ph_exec   = 1'b1; phase = 2'd2; end
      S_WB:     begin ph_wb     = 1'b1; phase = 2'd3; end
      default:  ;
    endcase
  end

  assign mem_req     = ph_fetch;
  assign busy        = (state_q != S_IDLE);
  assign instr_done  = done_q;
  assign instr_count = cnt_q;
  assign timeout_err = terr_q;

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Instruction-cycle sequencer for the nano processor.
- Steps FETCH -> DECODE -> EXEC -> WB per instruction and exposes one-hot phase strobes plus a 2-bit phase index.
- Runs a req/ack handshake with instruction memory during FETCH.
- Counts retired instructions and flags a fetch timeout. Consumes run/stall from control and drives the datapath phase enables.

Parameters:
- TIMEOUT, 15, maximum FETCH cycles without mem_ack before abort (1..255).
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- run  input  1  level; 1 = keep issuing instructions
- stall  input  1  level; holds DECODE/EXEC/WB in place
- mem_ack  input  1  memory acknowledges fetch (sampled only in FETCH)
- mem_req  output  1  fetch request, high throughout FETCH
- ph_fetch, ph_decode, ph_exec, ph_wb  output  1 each  one-hot phase strobes
- phase  output  2  0=FETCH 1=DECODE 2=EXEC 3=WB; 0 in IDLE
- instr_done  output  1  one-cycle retire pulse
- instr_count  output  CNT_W  retired instructions, wraps
- timeout_err  output  1  sticky fetch-timeout flag
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB. All outputs are registered or decoded from the state register only. No input-to-output combinational path.
- Reset (rst=1 at an edge, any state, including mid-instruction):
  - state=IDLE, wait counter=0, instr_count=0.
  - instr_done=0, timeout_err=0, mem_req=0, all ph_*=0, phase=0, busy=0.
- IDLE:
  - All strobes are 0.
  - If run=1 and timeout_err=0, go to FETCH at the next edge, so mem_req is high 1 cycle after run is sampled.
- FETCH:
  - mem_req=1, ph_fetch=1, phase=0.
  - mem_ack=1 sampled: go to DECODE and clear the wait counter. The fastest case is ack in the first FETCH cycle, giving 1 FETCH cycle.
  - mem_ack=0: increment the wait counter. When the counter reaches TIMEOUT-1 with still no ack (i.e. TIMEOUT FETCH cycles without ack), set timeout_err=1 and go to IDLE. mem_req drops the next cycle.
  - stall is ignored in FETCH.
- DECODE / EXEC / WB:
  - stall=1: hold state.
  - stall=0: advance DECODE -> EXEC -> WB.
- WB exit (stall=0):
  - Go to FETCH if run=1 and timeout_err=0, else IDLE.
  - At the same edge, instr_done <= 1 for exactly one cycle and instr_count increments by 1 (modulo 2^CNT_W, so 255 -> 0 for CNT_W=8).
- run deasserted mid-instruction: the current instruction completes through WB, then IDLE. No abort.
- mem_ack outside FETCH is ignored, with no state effect.
- timeout_err is cleared only by rst. While it is set, run is ignored and the block stays in IDLE.
- Throughput: with run=1, stall=0 and immediate ack, one instruction retires every 4 cycles back-to-back. instr_done pulses every 4th cycle.
- Invariant: exactly one ph_* is high when busy=1; none is high when busy=0.

Test Plan:
- Reset, then run=1 with mem_ack tied 1 for 12 cycles:
  - mem_req rises 1 cycle after run.
  - phase sequence is 0,1,2,3 repeating.
  - instr_done pulses 3 times.
  - instr_count=3.
- mem_ack delayed 5 cycles in FETCH:
  - ph_fetch and mem_req stay high for 6 cycles.
  - Then DECODE follows.
  - No timeout_err.
- mem_ack never asserted (TIMEOUT=15):
  - After 15 FETCH cycles, timeout_err=1, state IDLE, mem_req=0.
  - Re-asserting run has no effect until rst.
- stall=1 for 3 cycles while in EXEC:
  - ph_exec is held 4 cycles total and phase stays 2.
  - WB follows.
  - instr_done is delayed by 3 cycles.
- run dropped during DECODE:
  - The instruction finishes EXEC and WB.
  - instr_done pulses once.
  - Then busy=0 and no new mem_req.
- rst pulsed during EXEC with instr_count=255:
  - Next cycle all outputs are 0 and state is IDLE.
  - A separate run of 256 retirements from 255 shows the wrap to 0.
